// File: rtl/ov7670_config_seq.sv
// OV7670 register-table sequencer: walks a combinational init table and issues
// one SCCB transaction per entry, with delay/end markers and NACK retries.
module ov7670_config_seq #(
    parameter logic [23:0] DELAY_CYCLES = 24'd120000,
    parameter logic [1:0]  RETRIES      = 2'd2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic [5:0]  index_o,
    input  logic [16:0] entry_i,
    output logic        sccb_req_o,
    output logic [7:0]  sccb_addr_o,
    output logic [7:0]  sccb_data_o,
    output logic        sccb_rw_o,
    input  logic        sccb_done_i,
    input  logic        sccb_err_i,
    input  logic [7:0]  sccb_rdata_i,
    output logic [7:0]  rd_data_o,
    output logic        rd_valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        XFER,
        DELAY,
        NEXT,
        DONE,
        ERR
    } state_t;

    localparam logic [16:0] END_MARK   = {16'hffff, 1'b1};
    localparam logic [16:0] DELAY_MARK = {16'hf0f0, 1'b1};
    localparam logic [23:0] DELAY_LOAD = (DELAY_CYCLES == '0) ? 24'd1 : DELAY_CYCLES;

    state_t      state;
    state_t      state_next;
    logic [5:0]  index;
    logic [16:0] entry;
    logic [1:0]  retry_cnt;
    logic [23:0] delay_cnt;
    logic        req;
    logic        xfer_done;
    logic        can_retry;

    // Completion only counts while a request is actually outstanding.
    assign xfer_done = (state == XFER) && req && sccb_done_i;
    assign can_retry = (retry_cnt < RETRIES);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    state_next = FETCH;
                end
            end
            FETCH: state_next = DECODE;
            DECODE: begin
                if (entry_i == END_MARK) begin
                    state_next = DONE;
                end else if (entry_i == DELAY_MARK) begin
                    state_next = DELAY;
                end else begin
                    state_next = XFER;
                end
            end
            XFER: begin
                if (xfer_done) begin
                    if (!sccb_err_i) begin
                        state_next = NEXT;
                    end else if (!can_retry) begin
                        state_next = ERR;
                    end
                end
            end
            DELAY: begin
                if (delay_cnt <= 24'd1) begin
                    state_next = NEXT;
                end
            end
            NEXT: state_next = (index == 6'd63) ? DONE : FETCH;
            default: state_next = IDLE;
        endcase
    end

    // A retry drops req on the done edge and re-raises it one cycle later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            index      <= '0;
            entry      <= '0;
            retry_cnt  <= '0;
            delay_cnt  <= '0;
            req        <= 1'b0;
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start_i) begin
                        index     <= '0;
                        retry_cnt <= '0;
                    end
                end
                DECODE: begin
                    entry <= entry_i;
                    if (state_next == XFER) begin
                        req <= 1'b1;
                    end
                    if (state_next == DELAY) begin
                        delay_cnt <= DELAY_LOAD;
                    end
                end
                XFER: begin
                    if (xfer_done) begin
                        req <= 1'b0;
                        if (sccb_err_i) begin
                            if (can_retry) begin
                                retry_cnt <= retry_cnt + 2'd1;
                            end
                        end else if (!entry[0]) begin
                            rd_data_o  <= sccb_rdata_i;
                            rd_valid_o <= 1'b1;
                        end
                    end else if (!req) begin
                        req <= 1'b1;
                    end
                end
                DELAY: delay_cnt <= delay_cnt - 24'd1;
                NEXT: begin
                    retry_cnt <= '0;
                    if (index != 6'd63) begin
                        index <= index + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign index_o     = index;
    assign sccb_req_o  = req;
    assign sccb_addr_o = entry[16:9];
    assign sccb_data_o = entry[8:1];
    assign sccb_rw_o   = entry[0];
    assign busy_o      = !((state == IDLE) || (state == DONE) || (state == ERR));
    assign done_o      = (state == DONE);
    assign error_o     = (state == ERR);

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Scoreboard bench for ov7670_config_seq: directed tables, a behavioural SCCB
// responder, and monitors that pop expected requests and read results.
module tb_ov7670_config_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  index;
    logic [16:0] entry;
    logic        sccb_req;
    logic [7:0]  sccb_addr;
    logic [7:0]  sccb_data;
    logic        sccb_rw;
    logic        sccb_done;
    logic        sccb_err;
    logic [7:0]  sccb_rdata;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    ov7670_config_seq #(
        .DELAY_CYCLES(24'd10),
        .RETRIES     (2'd2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .index_o     (index),
        .entry_i     (entry),
        .sccb_req_o  (sccb_req),
        .sccb_addr_o (sccb_addr),
        .sccb_data_o (sccb_data),
        .sccb_rw_o   (sccb_rw),
        .sccb_done_i (sccb_done),
        .sccb_err_i  (sccb_err),
        .sccb_rdata_i(sccb_rdata),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error)
    );

    logic [16:0] tbl [64];
    always_comb entry = tbl[index];

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    logic [22:0] exp_q [$];
    logic [7:0]  exp_rd [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int unsigned idx, input logic [7:0] a, input logic [7:0] d, input logic rw);
        logic [5:0] i6;
        i6 = 6'(idx);
        exp_q.push_back({i6, a, d, rw});
    endtask

    // SCCB responder: done (with optional NACK) on the 5th cycle of each request.
    int  resp_lat = 5;
    logic nack_all = 1'b0;
    logic [7:0] resp_rdata = 8'h00;
    int  rcnt = 0;
    initial begin
        sccb_done  = 1'b0;
        sccb_err   = 1'b0;
        sccb_rdata = 8'h00;
    end
    always @(negedge clk) begin
        sccb_done  = 1'b0;
        sccb_err   = 1'b0;
        sccb_rdata = 8'h00;
        if (rst || !sccb_req) begin
            rcnt = 0;
        end else begin
            rcnt++;
            if (rcnt == resp_lat) begin
                sccb_done  = 1'b1;
                sccb_err   = nack_all;
                sccb_rdata = resp_rdata;
                rcnt = 0;
            end
        end
    end

    // Monitors: compare each new request and each read strobe against the queues.
    logic prev_req = 1'b0;
    logic prev_rv  = 1'b0;
    always @(negedge clk) begin
        logic [22:0] e;
        logic [7:0]  r;
        if (sccb_req && !prev_req) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got idx=%0d addr=%0h data=%0h rw=%0b expected none",
                         index, sccb_addr, sccb_data, sccb_rw);
            end else begin
                e = exp_q.pop_front();
                chk("req_fields", {41'd0, index, sccb_addr, sccb_data, sccb_rw}, {41'd0, e});
            end
        end
        if (rd_valid && prev_rv) begin
            checks++;
            errors++;
            $display("FAIL rd_valid_width: got strobe >1 cycle expected 1 cycle");
        end else if (rd_valid) begin
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd: got %0h expected none", rd_data);
            end else begin
                r = exp_rd.pop_front();
                chk("rd_data", {56'd0, rd_data}, {56'd0, r});
            end
        end
        prev_req = sccb_req;
        prev_rv  = rd_valid;
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int maxc, input string name);
        int n;
        n = 0;
        while (!(done || error) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (!(done || error)) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done/error expected one within %0d cycles", name, maxc);
        end
    endtask

    task automatic fill_table(input logic [16:0] v);
        for (int i = 0; i < 64; i++) tbl[i] = v;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int n;
        int unsigned t1;
        int unsigned t2;
        rst   = 1'b1;
        start = 1'b0;
        fill_table({16'hffff, 1'b1});

        // Reset state, then idle until start.
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            {28'd0, index, sccb_req, sccb_addr, sccb_data, sccb_rw, rd_data, rd_valid, busy, done, error},
            64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", {61'd0, busy, sccb_req, done}, 64'd0);

        // Three writes then the end marker; latency and start-while-busy.
        tbl[0] = {8'h12, 8'h80, 1'b1};
        tbl[1] = {8'h11, 8'h00, 1'b1};
        tbl[2] = {8'h0C, 8'h00, 1'b1};
        tbl[3] = {16'hffff, 1'b1};
        push(0, 8'h12, 8'h80, 1'b1);
        push(1, 8'h11, 8'h00, 1'b1);
        push(2, 8'h0C, 8'h00, 1'b1);
        pulse_start();
        chk("lat_fetch_noreq", {63'd0, sccb_req}, 64'd0);
        chk("busy_in_fetch", {63'd0, busy}, 64'd1);
        @(negedge clk);
        chk("lat_decode_noreq", {63'd0, sccb_req}, 64'd0);
        @(negedge clk);
        chk("lat_xfer_req", {63'd0, sccb_req}, 64'd1);
        n = 0;
        while (!(index == 6'd1 && sccb_req) && n < 100) begin
            @(negedge clk);
            n++;
        end
        pulse_start();
        wait_end(200, "t_writes");
        chk("writes_status", {59'd0, done, error, busy, 1'b0, 1'b0}, {59'd0, 5'b10000});
        chk("writes_index", {58'd0, index}, 64'd3);
        chk("writes_q_empty", 64'(exp_q.size()), 64'd0);

        // Delay marker at index 1 with DELAY_CYCLES=10.
        fill_table({16'hffff, 1'b1});
        tbl[0] = {8'h12, 8'h80, 1'b1};
        tbl[1] = {16'hf0f0, 1'b1};
        tbl[2] = {8'h3A, 8'h04, 1'b1};
        push(0, 8'h12, 8'h80, 1'b1);
        push(2, 8'h3A, 8'h04, 1'b1);
        pulse_start();
        n = 0;
        while (index != 6'd1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        t1 = cyc;
        n = 0;
        while (!(sccb_req && index == 6'd2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        t2 = cyc;
        // index 1 appears entering FETCH: FETCH+DECODE, 10 DELAY, NEXT+FETCH+DECODE.
        chk("delay_timing", 64'(t2 - t1), 64'd15);
        wait_end(200, "t_delay");
        chk("delay_done", {62'd0, done, error}, 64'd2);
        chk("delay_index", {58'd0, index}, 64'd3);
        chk("delay_q_empty", 64'(exp_q.size()), 64'd0);

        // NACK on every attempt: 1 + RETRIES requests, then ERR.
        fill_table({16'hffff, 1'b1});
        tbl[0] = {8'h21, 8'h55, 1'b1};
        nack_all = 1'b1;
        push(0, 8'h21, 8'h55, 1'b1);
        push(0, 8'h21, 8'h55, 1'b1);
        push(0, 8'h21, 8'h55, 1'b1);
        pulse_start();
        wait_end(200, "t_nack");
        nack_all = 1'b0;
        repeat (3) @(negedge clk);
        chk("nack_status", {61'd0, error, busy, done}, 64'd4);
        chk("nack_index", {58'd0, index}, 64'd0);
        chk("nack_q_empty", 64'(exp_q.size()), 64'd0);

        // Read transaction.
        fill_table({16'hffff, 1'b1});
        tbl[0] = {16'h0A76, 1'b0};
        resp_rdata = 8'h76;
        push(0, 8'h0A, 8'h76, 1'b0);
        exp_rd.push_back(8'h76);
        pulse_start();
        wait_end(200, "t_read");
        resp_rdata = 8'h00;
        chk("read_done", {62'd0, done, error}, 64'd2);
        chk("read_data_held", {56'd0, rd_data}, 64'h76);
        chk("read_q_empty", 64'(exp_q.size() + exp_rd.size()), 64'd0);

        // No end marker: 64 writes then DONE at index 63.
        for (int i = 0; i < 64; i++) begin
            tbl[i] = {8'(i), ~8'(i), 1'b1};
            push(i, 8'(i), ~8'(i), 1'b1);
        end
        pulse_start();
        wait_end(1500, "t_full");
        chk("full_done", {62'd0, done, error}, 64'd2);
        chk("full_index", {58'd0, index}, 64'd63);
        chk("full_q_empty", 64'(exp_q.size()), 64'd0);

        // Reset during XFER at index 5, then restart from 0.
        fill_table({16'hffff, 1'b1});
        for (int i = 0; i < 7; i++) tbl[i] = {8'h40 + 8'(i), 8'(i), 1'b1};
        for (int i = 0; i < 6; i++) push(i, 8'h40 + 8'(i), 8'(i), 1'b1);
        pulse_start();
        n = 0;
        while (!(index == 6'd5 && sccb_req) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reached_idx5", {62'd0, index == 6'd5, sccb_req}, 64'd3);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_req", {63'd0, sccb_req}, 64'd0);
        chk("rst_async_index", {58'd0, index}, 64'd0);
        chk("rst_async_busy", {63'd0, busy}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_q_empty", 64'(exp_q.size()), 64'd0);
        repeat (4) @(negedge clk);
        chk("rst_stays_idle", {61'd0, busy, sccb_req, done}, 64'd0);
        for (int i = 0; i < 7; i++) push(i, 8'h40 + 8'(i), 8'(i), 1'b1);
        pulse_start();
        wait_end(300, "t_restart");
        chk("restart_done", {62'd0, done, error}, 64'd2);
        chk("restart_index", {58'd0, index}, 64'd7);
        chk("restart_q_empty", 64'(exp_q.size()), 64'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ov7670_config_seq.md
OV7670_CONFIG_SEQ -- requirements
Module: ov7670_config_seq

Interface
REQ-001 SHALL have parameter DELAY_CYCLES, default 24'd120000, giving the number of clk_i cycles waited at a delay marker (10 ms at 12 MHz).
REQ-002 SHALL have parameter RETRIES, default 2'd2, giving the number of extra attempts after a NACKed transaction.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port start_i, input, 1 bit: a one-cycle pulse that starts the configuration sequence.
REQ-006 SHALL have port index_o, output, 6 bits: register-table index presented to the combinational init table.
REQ-007 SHALL have port entry_i, input, 17 bits: table entry {addr[15:8], value[7:0], rw_flag} for index_o; rw_flag 1 = write, 0 = read.
REQ-008 SHALL have port sccb_req_o, output, 1 bit: transaction request to the SCCB master, held until done.
REQ-009 SHALL have ports sccb_addr_o (8 bits), sccb_data_o (8 bits) and sccb_rw_o (1 bit), all outputs: transaction fields, stable while sccb_req_o=1.
REQ-010 SHALL have ports sccb_done_i, input, 1 bit (one-cycle completion pulse), and sccb_err_i, input, 1 bit (NACK flag, valid with done).
REQ-011 SHALL have port sccb_rdata_i, input, 8 bits: read data, valid with sccb_done_i.
REQ-012 SHALL have ports rd_data_o, output, 8 bits, and rd_valid_o, output, 1 bit: captured read result and its one-cycle strobe.
REQ-013 SHALL have ports busy_o, done_o and error_o, all outputs, 1 bit each: sequence status.

Function
REQ-014 States SHALL be IDLE, FETCH, DECODE, XFER, DELAY, NEXT, DONE and ERR.
- IDLE/DONE/ERR + start_i -> FETCH, with index_o=0 and the retry count cleared.
- start_i in any other state SHALL be ignored.
REQ-015 FETCH SHALL last exactly one cycle to let the table settle; DECODE SHALL register entry_i.
REQ-016 In DECODE, entry {16'hffff,1} SHALL go to DONE and entry {16'hf0f0,1} SHALL go to DELAY; any other entry SHALL go to XFER.
REQ-017 In XFER, sccb_req_o SHALL be 1 from the first XFER cycle, with addr = entry[16:9], data = entry[8:1], rw = entry[0].
- sccb_req_o SHALL drop the cycle after sccb_done_i.
- sccb_done_i outside XFER SHALL be ignored.
REQ-018 On sccb_done_i with sccb_err_i=0, the block SHALL go to NEXT.
- If rw=0, rd_data_o SHALL load sccb_rdata_i and rd_valid_o SHALL pulse for 1 cycle.
REQ-019 On sccb_done_i with sccb_err_i=1:
- if retries used < RETRIES, it SHALL increment the retry count and re-enter XFER with the same fields, with sccb_req_o low for at least 1 cycle in between;
- otherwise it SHALL go to ERR.
REQ-020 DELAY SHALL count DELAY_CYCLES cycles (a 24-bit down-counter) and then go to NEXT; DELAY_CYCLES=0 SHALL behave as 1.
REQ-021 NEXT SHALL clear the retry count and increment index_o, then go to FETCH.
- If index_o=63 at NEXT, it SHALL go to DONE instead; no wrap to 0.
REQ-022 busy_o SHALL be 1 in every state except IDLE, DONE and ERR.
- done_o SHALL be 1 only in DONE; error_o SHALL be 1 only in ERR.
- index_o SHALL hold the failing index while in ERR.
REQ-023 Start-to-first-sccb_req_o latency SHALL be 3 cycles: FETCH, DECODE, then XFER.

Reset
REQ-024 While rst_i=1, the block SHALL be in IDLE and all outputs SHALL be 0: index_o, sccb_*_o, rd_data_o, rd_valid_o, busy_o, done_o, error_o.
REQ-025 Assertion of rst_i mid-transaction SHALL drop sccb_req_o immediately (asynchronously) and abandon the sequence; there is no resume.
REQ-026 After rst_i is released, the block SHALL remain in IDLE until start_i.

Verification
REQ-027 Table with 3 writes then ffff, done returned after 5 cycles each -> 3 requests with (12,80,1), (11,00,1), (0C,00,1); done_o=1; index_o=3.
REQ-028 Entry 1 = f0f0, DELAY_CYCLES=10 -> no request at index 1; the request for index 2 rises exactly 10 DELAY cycles plus 3 cycles (NEXT, FETCH, DECODE) after DELAY entry.
REQ-029 NACK on every attempt, RETRIES=2 -> exactly 3 requests for index 0; then error_o=1, index_o=0, busy_o=0.
REQ-030 Entry {16'h0A76,0}, sccb_rdata_i=8'h76 -> request with rw=0; rd_data_o=8'h76 with a 1-cycle rd_valid_o.
REQ-031 Table with no end marker (all writes) -> 64 requests, then done_o=1 with index_o=63 and no wrap.
REQ-032 rst_i pulsed during XFER at index 5 -> sccb_req_o=0 asynchronously and index_o=0; start_i afterwards restarts at index 0.
